// File: rtl/msg_load_controller_if.sv
// Byte-stream, arbitration and RAM write-port bundle for the message load controller.
// The master side feeds payload bytes and core requests; the slave side is the controller.
interface msg_load_controller_if #(
  parameter int WORD_BYTES = 2,
  parameter int P_ADDR_W   = 4,
  parameter int M_ADDR_W   = 6
);
  logic [7:0]              msg_in;
  logic                    msg_valid;
  logic                    particle_flag;
  logic                    map_flag;
  logic                    core_req;
  logic                    core_grant;
  logic                    p_we;
  logic [P_ADDR_W-1:0]     p_addr;
  logic [8*WORD_BYTES-1:0] p_wdata;
  logic                    m_we;
  logic [M_ADDR_W-1:0]     m_addr;
  logic [8*WORD_BYTES-1:0] m_wdata;
  logic                    particles_loaded;
  logic                    map_loaded;
  logic                    frame_err;

  modport master (
    output msg_in, msg_valid, particle_flag, map_flag, core_req,
    input  core_grant, p_we, p_addr, p_wdata, m_we, m_addr, m_wdata,
           particles_loaded, map_loaded, frame_err
  );

  modport slave (
    input  msg_in, msg_valid, particle_flag, map_flag, core_req,
    output core_grant, p_we, p_addr, p_wdata, m_we, m_addr, m_wdata,
           particles_loaded, map_loaded, frame_err
  );
endinterface

// File: rtl/msg_load_controller.sv
// Packs a byte stream into particle/map RAM words and arbitrates the particle RAM with the filter core.
// state   | meaning
// IDLE    | waiting for exactly one payload flag; core may own the particle RAM
// LOAD_P  | packing particle words into the one-deep pending register
// LOAD_M  | packing map words, each written one cycle after completion
// FLUSH_P | particle flag fell with a word still pending; wait for its write
module msg_load_controller #(
  parameter int WORD_BYTES = 2,
  parameter int P_ADDR_W   = 4,
  parameter int M_ADDR_W   = 6
) (
  input logic clk,
  input logic reset,
  msg_load_controller_if.slave bus
);
  localparam int W    = 8*WORD_BYTES;
  localparam int BC_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BC_W-1:0] LAST = BC_W'(WORD_BYTES-1);

  typedef enum logic [1:0] {IDLE, LOAD_P, LOAD_M, FLUSH_P} state_t;

  state_t              state, state_n;
  logic                p_arm, m_arm;
  logic [BC_W-1:0]     bcnt;
  logic [W-1:0]        pack, word;
  logic                pend_valid;
  logic [W-1:0]        pend_data;
  logic [P_ADDR_W-1:0] p_addr;
  logic [M_ADDR_W-1:0] m_addr;
  logic                m_we;
  logic [W-1:0]        m_wdata;
  logic                grant, grant_n;
  logic                p_loaded, m_loaded, ferr;

  logic start_p, start_m, both_err, fall, accept, complete, p_we, pend_busy;
  logic ld_p_n, ld_m_n, drop;

  assign word      = W'({pack, bus.msg_in});
  assign p_we      = pend_valid && !grant;
  // A pending word being written this cycle frees the slot for the next one.
  assign pend_busy = pend_valid && !p_we;
  assign complete  = accept && (bcnt == LAST);
  assign drop      = complete && (state == LOAD_P) && pend_busy;

  always_comb begin
    state_n  = state;
    start_p  = 1'b0;
    start_m  = 1'b0;
    both_err = 1'b0;
    fall     = 1'b0;
    accept   = 1'b0;
    ld_p_n   = 1'b0;
    ld_m_n   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.particle_flag && bus.map_flag) begin
          both_err = p_arm || m_arm;
        end else if (bus.particle_flag && p_arm) begin
          state_n = LOAD_P;
          start_p = 1'b1;
        end else if (bus.map_flag && m_arm) begin
          state_n = LOAD_M;
          start_m = 1'b1;
        end
      end
      LOAD_P: begin
        if (!bus.particle_flag) begin
          fall = 1'b1;
          if (pend_busy) begin
            state_n = FLUSH_P;
          end else begin
            state_n = IDLE;
            ld_p_n  = 1'b1;
          end
        end else begin
          accept = bus.msg_valid;
        end
      end
      LOAD_M: begin
        if (!bus.map_flag) begin
          fall    = 1'b1;
          state_n = IDLE;
          ld_m_n  = 1'b1;
        end else begin
          accept = bus.msg_valid;
        end
      end
      FLUSH_P: begin
        if (p_we) begin
          state_n = IDLE;
          ld_p_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (grant) grant_n = bus.core_req;
    else       grant_n = bus.core_req && (state == IDLE || state == LOAD_M) && !pend_valid;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      p_arm      <= 1'b0;
      m_arm      <= 1'b0;
      bcnt       <= '0;
      pack       <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      p_addr     <= '0;
      m_addr     <= '0;
      m_we       <= 1'b0;
      m_wdata    <= '0;
      grant      <= 1'b0;
      p_loaded   <= 1'b0;
      m_loaded   <= 1'b0;
      ferr       <= 1'b0;
    end else begin
      state    <= state_n;
      // A flag already high at reset release must drop once before it can start a frame.
      p_arm    <= p_arm || !bus.particle_flag;
      m_arm    <= m_arm || !bus.map_flag;
      grant    <= grant_n;
      p_loaded <= ld_p_n;
      m_loaded <= ld_m_n;
      ferr     <= ferr || both_err || (fall && bcnt != '0) || drop;

      if (start_p || start_m || fall) bcnt <= '0;
      else if (accept)                bcnt <= (bcnt == LAST) ? '0 : bcnt + 1'b1;
      if (accept) pack <= word;

      if (p_we) pend_valid <= 1'b0;
      if (complete && state == LOAD_P && !pend_busy) begin
        pend_valid <= 1'b1;
        pend_data  <= word;
      end

      if (start_p)   p_addr <= '0;
      else if (p_we) p_addr <= p_addr + 1'b1;

      m_we <= complete && (state == LOAD_M);
      if (complete && state == LOAD_M) m_wdata <= word;
      if (start_m)   m_addr <= '0;
      else if (m_we) m_addr <= m_addr + 1'b1;
    end
  end

  assign bus.core_grant       = grant;
  assign bus.p_we             = p_we;
  assign bus.p_addr           = p_addr;
  assign bus.p_wdata          = pend_data;
  assign bus.m_we             = m_we;
  assign bus.m_addr           = m_addr;
  assign bus.m_wdata          = m_wdata;
  assign bus.particles_loaded = p_loaded;
  assign bus.map_loaded       = m_loaded;
  assign bus.frame_err        = ferr;
endmodule

// File: tb/tb_msg_load_controller.sv
// Directed bench for msg_load_controller: per-cycle vector table plus a full map frame sequence.
module tb_msg_load_controller;
  logic clk;
  logic reset;

  msg_load_controller_if #(.WORD_BYTES(2), .P_ADDR_W(4), .M_ADDR_W(6)) bif ();

  msg_load_controller #(.WORD_BYTES(2), .P_ADDR_W(4), .M_ADDR_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst_b, pf, mf, v;
    logic [7:0]  b;
    logic        cr;
    logic        pwe;
    logic [3:0]  pa;
    logic [15:0] pwd;
    logic        mwe;
    logic [5:0]  ma;
    logic        g, pl, ml, er;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(string n, logic rst_b, logic pf, logic mf, logic v,
                              logic [7:0] b, logic cr, logic pwe, logic [3:0] pa,
                              logic [15:0] pwd, logic g, logic pl, logic er);
    vec_t r;
    r.name = n; r.rst_b = rst_b; r.pf = pf; r.mf = mf; r.v = v; r.b = b; r.cr = cr;
    r.pwe = pwe; r.pa = pa; r.pwd = pwd; r.mwe = 1'b0; r.ma = 6'd0;
    r.g = g; r.pl = pl; r.ml = 1'b0; r.er = er;
    return r;
  endfunction

  task automatic drive(logic rst_b, logic pf, logic mf, logic v, logic [7:0] b, logic cr);
    reset             = rst_b;
    bif.particle_flag = pf;
    bif.map_flag      = mf;
    bif.msg_valid     = v;
    bif.msg_in        = b;
    bif.core_req      = cr;
  endtask

  task automatic check(string name, logic ok, string got, string want);
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %s, want %s", name, got, want);
    end
  endtask

  task automatic apply(vec_t t);
    logic ok;
    drive(t.rst_b, t.pf, t.mf, t.v, t.b, t.cr);
    @(negedge clk);
    ok = (bif.p_we === t.pwe) && (bif.p_addr === t.pa) && (bif.p_wdata === t.pwd) &&
         (bif.m_we === t.mwe) && (bif.m_addr === t.ma) && (bif.core_grant === t.g) &&
         (bif.particles_loaded === t.pl) && (bif.map_loaded === t.ml) &&
         (bif.frame_err === t.er);
    check(t.name, ok,
      $sformatf("p_we=%b p_addr=%0d p_wdata=%h m_we=%b m_addr=%0d grant=%b pl=%b ml=%b err=%b",
        bif.p_we, bif.p_addr, bif.p_wdata, bif.m_we, bif.m_addr, bif.core_grant,
        bif.particles_loaded, bif.map_loaded, bif.frame_err),
      $sformatf("p_we=%b p_addr=%0d p_wdata=%h m_we=%b m_addr=%0d grant=%b pl=%b ml=%b err=%b",
        t.pwe, t.pa, t.pwd, t.mwe, t.ma, t.g, t.pl, t.ml, t.er));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nw, nml, nbad;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    //            name       rst pf mf v  byte  cr | pwe pa  wdata    g  pl er
    // Two-word particle frame, core idle
    vecs.push_back(mk("a_rst",   0, 0, 0, 0, 8'h00, 0,  0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk("a_arm",   1, 0, 0, 0, 8'h00, 0,  0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk("a_go",    1, 1, 0, 0, 8'h00, 0,  0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk("a_b0",    1, 1, 0, 1, 8'h11, 0,  0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk("a_b1",    1, 1, 0, 1, 8'h22, 0,  0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk("a_b2",    1, 1, 0, 1, 8'h33, 0,  1, 0, 16'h1122, 0, 0, 0));
    vecs.push_back(mk("a_b3",    1, 1, 0, 1, 8'h44, 0,  0, 1, 16'h1122, 0, 0, 0));
    vecs.push_back(mk("a_fall",  1, 0, 0, 0, 8'h00, 0,  1, 1, 16'h3344, 0, 0, 0));
    vecs.push_back(mk("a_pl",    1, 0, 0, 0, 8'h00, 0,  0, 2, 16'h3344, 0, 1, 0));
    vecs.push_back(mk("a_quiet", 1, 0, 0, 0, 8'h00, 0,  0, 2, 16'h3344, 0, 0, 0));
    // Three-byte frame: one write, partial byte dropped, error
    vecs.push_back(mk("b_go",    1, 1, 0, 0, 8'h00, 0,  0, 2, 16'h3344, 0, 0, 0));
    vecs.push_back(mk("b_b0",    1, 1, 0, 1, 8'hAA, 0,  0, 0, 16'h3344, 0, 0, 0));
    vecs.push_back(mk("b_b1",    1, 1, 0, 1, 8'hBB, 0,  0, 0, 16'h3344, 0, 0, 0));
    vecs.push_back(mk("b_b2",    1, 1, 0, 1, 8'hCC, 0,  1, 0, 16'hAABB, 0, 0, 0));
    vecs.push_back(mk("b_fall",  1, 0, 0, 0, 8'h00, 0,  0, 1, 16'hAABB, 0, 0, 0));
    vecs.push_back(mk("b_pl",    1, 0, 0, 0, 8'h00, 0,  0, 1, 16'hAABB, 0, 1, 1));
    vecs.push_back(mk("b_quiet", 1, 0, 0, 0, 8'h00, 0,  0, 1, 16'hAABB, 0, 0, 1));
    // Core holds grant: first word pends, second dropped, write after release
    vecs.push_back(mk("c_rst",   0, 0, 0, 0, 8'h00, 0,  0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk("c_arm",   1, 0, 0, 0, 8'h00, 0,  0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk("c_req",   1, 0, 0, 0, 8'h00, 1,  0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk("c_go",    1, 1, 0, 0, 8'h00, 1,  0, 0, 16'h0000, 1, 0, 0));
    vecs.push_back(mk("c_b0",    1, 1, 0, 1, 8'h11, 1,  0, 0, 16'h0000, 1, 0, 0));
    vecs.push_back(mk("c_b1",    1, 1, 0, 1, 8'h22, 1,  0, 0, 16'h0000, 1, 0, 0));
    vecs.push_back(mk("c_b2",    1, 1, 0, 1, 8'h33, 1,  0, 0, 16'h1122, 1, 0, 0));
    vecs.push_back(mk("c_b3",    1, 1, 0, 1, 8'h44, 1,  0, 0, 16'h1122, 1, 0, 0));
    vecs.push_back(mk("c_rel",   1, 1, 0, 0, 8'h00, 0,  0, 0, 16'h1122, 1, 0, 1));
    vecs.push_back(mk("c_wr0",   1, 1, 0, 0, 8'h00, 0,  1, 0, 16'h1122, 0, 0, 1));
    vecs.push_back(mk("c_b4",    1, 1, 0, 1, 8'h55, 0,  0, 1, 16'h1122, 0, 0, 1));
    vecs.push_back(mk("c_b5",    1, 1, 0, 1, 8'h66, 0,  0, 1, 16'h1122, 0, 0, 1));
    vecs.push_back(mk("c_wr1",   1, 1, 0, 0, 8'h00, 0,  1, 1, 16'h5566, 0, 0, 1));
    vecs.push_back(mk("c_fall",  1, 0, 0, 0, 8'h00, 0,  0, 2, 16'h5566, 0, 0, 1));
    vecs.push_back(mk("c_pl",    1, 0, 0, 0, 8'h00, 0,  0, 2, 16'h5566, 0, 1, 1));
    // Flag falls with a word pending under grant -> flush; request during LOAD_P waits
    vecs.push_back(mk("d_req",   1, 0, 0, 0, 8'h00, 1,  0, 2, 16'h5566, 0, 0, 1));
    vecs.push_back(mk("d_go",    1, 1, 0, 0, 8'h00, 1,  0, 2, 16'h5566, 1, 0, 1));
    vecs.push_back(mk("d_b0",    1, 1, 0, 1, 8'h77, 1,  0, 0, 16'h5566, 1, 0, 1));
    vecs.push_back(mk("d_b1",    1, 1, 0, 1, 8'h88, 1,  0, 0, 16'h5566, 1, 0, 1));
    vecs.push_back(mk("d_fall",  1, 0, 0, 0, 8'h00, 1,  0, 0, 16'h7788, 1, 0, 1));
    vecs.push_back(mk("d_flush", 1, 0, 0, 0, 8'h00, 0,  0, 0, 16'h7788, 1, 0, 1));
    vecs.push_back(mk("d_fwr",   1, 0, 0, 0, 8'h00, 0,  1, 0, 16'h7788, 0, 0, 1));
    vecs.push_back(mk("d_fpl",   1, 0, 0, 0, 8'h00, 0,  0, 1, 16'h7788, 0, 1, 1));
    vecs.push_back(mk("d_go2",   1, 1, 0, 0, 8'h00, 0,  0, 1, 16'h7788, 0, 0, 1));
    vecs.push_back(mk("d_wait",  1, 1, 0, 0, 8'h00, 1,  0, 0, 16'h7788, 0, 0, 1));
    vecs.push_back(mk("d_fall2", 1, 0, 0, 0, 8'h00, 1,  0, 0, 16'h7788, 0, 0, 1));
    vecs.push_back(mk("d_idle",  1, 0, 0, 0, 8'h00, 1,  0, 0, 16'h7788, 0, 1, 1));
    vecs.push_back(mk("d_gnt",   1, 0, 0, 0, 8'h00, 0,  0, 0, 16'h7788, 1, 0, 1));
    vecs.push_back(mk("d_gfall", 1, 0, 0, 0, 8'h00, 0,  0, 0, 16'h7788, 0, 0, 1));
    // Reset mid-frame with a word pending; flag stays high afterwards
    vecs.push_back(mk("e_rst",   0, 0, 0, 0, 8'h00, 0,  0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk("e_arm",   1, 0, 0, 0, 8'h00, 0,  0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk("e_req",   1, 0, 0, 0, 8'h00, 1,  0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk("e_go",    1, 1, 0, 0, 8'h00, 1,  0, 0, 16'h0000, 1, 0, 0));
    vecs.push_back(mk("e_b0",    1, 1, 0, 1, 8'h12, 1,  0, 0, 16'h0000, 1, 0, 0));
    vecs.push_back(mk("e_b1",    1, 1, 0, 1, 8'h34, 1,  0, 0, 16'h0000, 1, 0, 0));
    vecs.push_back(mk("e_pend",  1, 1, 0, 0, 8'h00, 1,  0, 0, 16'h1234, 1, 0, 0));
    vecs.push_back(mk("e_midrst",0, 1, 0, 0, 8'h00, 0,  0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk("e_ign0",  1, 1, 0, 1, 8'h56, 0,  0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk("e_ign1",  1, 1, 0, 1, 8'h78, 0,  0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk("e_low",   1, 0, 0, 0, 8'h00, 0,  0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk("e_quiet", 1, 0, 0, 0, 8'h00, 0,  0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk("e_both",  1, 1, 1, 0, 8'h00, 0,  0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk("e_berr",  1, 0, 0, 0, 8'h00, 0,  0, 0, 16'h0000, 0, 0, 1));

    @(posedge clk);
    #1;
    foreach (vecs[i]) apply(vecs[i]);

    // Full 128-byte map frame: 64 writes, address wraps, one map_loaded pulse
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1;
    nw = 0; nml = 0; nbad = 0;
    for (int i = 0; i < 134; i++) begin
      if (i < 128) drive(1'b1, 1'b0, 1'b1, 1'b1, 8'(i), 1'b0);
      else         drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      @(negedge clk);
      if (bif.m_we === 1'b1) begin
        check($sformatf("map_wr%0d", nw),
              (bif.m_addr === 6'(nw)) && (bif.m_wdata === {8'(2*nw), 8'(2*nw+1)}),
              $sformatf("addr=%0d data=%h", bif.m_addr, bif.m_wdata),
              $sformatf("addr=%0d data=%h", 6'(nw), {8'(2*nw), 8'(2*nw+1)}));
        nw++;
      end
      if (bif.map_loaded === 1'b1) nml++;
      if (bif.p_we !== 1'b0) nbad++;
      @(posedge clk); #1;
    end
    check("map_writes",   nw == 64,               $sformatf("%0d", nw),   "64");
    check("map_loaded",   nml == 1,               $sformatf("%0d", nml),  "1");
    check("map_addr_wrap", bif.m_addr === 6'd0,   $sformatf("%0d", bif.m_addr), "0");
    check("map_no_perr",  (bif.frame_err === 1'b0) && (nbad == 0),
          $sformatf("err=%b p_we_cycles=%0d", bif.frame_err, nbad), "err=0 p_we_cycles=0");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
